// File: rtl/l1_l2_arbiter.sv
// Round-robin arbiter sharing the single L2 request port between L1i and L1d.
// state | meaning: IDLE no grant | SERVE_I/SERVE_D strobe L2 for owner | DONE ready pulse to owner
module l1_l2_arbiter #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              proc_reset,
  input  logic              L1i_read_i,
  input  logic [ADDR_W-1:0] L1i_addr_i,
  output logic [DATA_W-1:0] L1i_rdata_o,
  output logic              L1i_ready,
  input  logic              L1d_read_i,
  input  logic              L1d_write_i,
  input  logic [ADDR_W-1:0] L1d_addr_i,
  input  logic [DATA_W-1:0] L1d_wdata_i,
  output logic [DATA_W-1:0] L1d_rdata_o,
  output logic              L1d_ready,
  output logic              L2_read,
  output logic              L2_write,
  output logic [ADDR_W-1:0] L2_addr,
  output logic [DATA_W-1:0] L2_wdata,
  input  logic [DATA_W-1:0] L2_rdata,
  input  logic              L2_ready,
  output logic              arb_busy_o,
  output logic              arb_grant_d_o
);

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, DONE} state_t;

  state_t state, state_nxt;
  logic   last_grant, last_grant_nxt;
  logic   req_i, req_d;

  assign req_i = L1i_read_i;
  assign req_d = L1d_read_i | L1d_write_i;

  always_ff @(posedge clk) begin
    if (proc_reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    case (state)
      IDLE: begin
        if (req_i && (!req_d || last_grant)) begin
          state_nxt      = SERVE_I;
          last_grant_nxt = 1'b0;
        end else if (req_d) begin
          state_nxt      = SERVE_D;
          last_grant_nxt = 1'b1;
        end
      end
      SERVE_I: begin
        if (L2_ready)   state_nxt = DONE;
        else if (!req_i) state_nxt = IDLE;
      end
      SERVE_D: begin
        if (L2_ready)   state_nxt = DONE;
        else if (!req_d) state_nxt = IDLE;
      end
      DONE: begin
        // the owner's request is stale here; only the other side may be granted
        if (last_grant && req_i) begin
          state_nxt      = SERVE_I;
          last_grant_nxt = 1'b0;
        end else if (!last_grant && req_d) begin
          state_nxt      = SERVE_D;
          last_grant_nxt = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    L2_read  = 1'b0;
    L2_write = 1'b0;
    L2_addr  = '0;
    L2_wdata = '0;
    case (state)
      SERVE_I: begin
        L2_read = 1'b1;
        L2_addr = L1i_addr_i;
      end
      SERVE_D: begin
        L2_write = L1d_write_i;
        L2_read  = L1d_read_i & ~L1d_write_i;
        L2_addr  = L1d_addr_i;
        L2_wdata = L1d_wdata_i;
      end
      default: ;
    endcase
  end

  assign L1i_ready     = (state == DONE) && !last_grant;
  assign L1d_ready     = (state == DONE) &&  last_grant;
  assign arb_busy_o    = (state == SERVE_I) || (state == SERVE_D);
  assign arb_grant_d_o = last_grant;

  always_ff @(posedge clk) begin
    if (proc_reset) begin
      L1i_rdata_o <= '0;
      L1d_rdata_o <= '0;
    end else begin
      if (state == SERVE_I && L2_ready)
        L1i_rdata_o <= L2_rdata;
      if (state == SERVE_D && L2_ready && L2_read)
        L1d_rdata_o <= L2_rdata;
    end
  end

endmodule

// File: tb/tb_l1_l2_arbiter.sv
// Directed bench for l1_l2_arbiter; inputs driven and outputs sampled 1 time unit after posedge.
module tb_l1_l2_arbiter;
  localparam int ADDR_W = 28;
  localparam int DATA_W = 128;

  logic              clk = 1'b0;
  logic              proc_reset;
  logic              L1i_read_i;
  logic [ADDR_W-1:0] L1i_addr_i;
  logic [DATA_W-1:0] L1i_rdata_o;
  logic              L1i_ready;
  logic              L1d_read_i;
  logic              L1d_write_i;
  logic [ADDR_W-1:0] L1d_addr_i;
  logic [DATA_W-1:0] L1d_wdata_i;
  logic [DATA_W-1:0] L1d_rdata_o;
  logic              L1d_ready;
  logic              L2_read;
  logic              L2_write;
  logic [ADDR_W-1:0] L2_addr;
  logic [DATA_W-1:0] L2_wdata;
  logic [DATA_W-1:0] L2_rdata;
  logic              L2_ready;
  logic              arb_busy_o;
  logic              arb_grant_d_o;

  int n_chk  = 0;
  int n_fail = 0;

  localparam logic [DATA_W-1:0] PAT_A5 = {16{8'hA5}};
  localparam logic [DATA_W-1:0] PAT_55 = {16{8'h55}};
  localparam logic [DATA_W-1:0] PAT_FF = {16{8'hFF}};

  l1_l2_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .proc_reset(proc_reset),
    .L1i_read_i(L1i_read_i), .L1i_addr_i(L1i_addr_i),
    .L1i_rdata_o(L1i_rdata_o), .L1i_ready(L1i_ready),
    .L1d_read_i(L1d_read_i), .L1d_write_i(L1d_write_i),
    .L1d_addr_i(L1d_addr_i), .L1d_wdata_i(L1d_wdata_i),
    .L1d_rdata_o(L1d_rdata_o), .L1d_ready(L1d_ready),
    .L2_read(L2_read), .L2_write(L2_write), .L2_addr(L2_addr),
    .L2_wdata(L2_wdata), .L2_rdata(L2_rdata), .L2_ready(L2_ready),
    .arb_busy_o(arb_busy_o), .arb_grant_d_o(arb_grant_d_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic do_reset();
    proc_reset = 1'b1;
    tick();
    tick();
    proc_reset = 1'b0;
  endtask

  initial begin
    logic [DATA_W-1:0] d_exp;
    logic [DATA_W-1:0] i_exp;
    logic              own_d;

    proc_reset  = 1'b1;
    L1i_read_i  = 1'b0;
    L1i_addr_i  = '0;
    L1d_read_i  = 1'b0;
    L1d_write_i = 1'b0;
    L1d_addr_i  = '0;
    L1d_wdata_i = '0;
    L2_rdata    = '0;
    L2_ready    = 1'b0;
    do_reset();

    // reset state
    chk("rst_busy",    128'(arb_busy_o), 128'(0));
    chk("rst_grant_d", 128'(arb_grant_d_o), 128'(1));
    chk("rst_i_ready", 128'(L1i_ready), 128'(0));
    chk("rst_d_ready", 128'(L1d_ready), 128'(0));
    chk("rst_l2_read", 128'(L2_read), 128'(0));
    chk("rst_l2_write",128'(L2_write), 128'(0));
    chk("rst_i_rdata", 128'(L1i_rdata_o), 128'(0));
    chk("rst_d_rdata", 128'(L1d_rdata_o), 128'(0));

    // I-only read, L2 hit in first SERVE cycle
    L1i_read_i = 1'b1;
    L1i_addr_i = 28'h0000010;
    chk("t1_c0_read", 128'(L2_read), 128'(0));
    tick();
    chk("t1_c1_read", 128'(L2_read), 128'(1));
    chk("t1_c1_addr", 128'(L2_addr), 128'(28'h0000010));
    chk("t1_c1_busy", 128'(arb_busy_o), 128'(1));
    chk("t1_c1_grant",128'(arb_grant_d_o), 128'(0));
    L2_ready = 1'b1;
    L2_rdata = PAT_A5;
    tick();
    chk("t1_c2_i_ready", 128'(L1i_ready), 128'(1));
    chk("t1_c2_d_ready", 128'(L1d_ready), 128'(0));
    chk("t1_c2_i_rdata", 128'(L1i_rdata_o), 128'(PAT_A5));
    chk("t1_c2_read",    128'(L2_read), 128'(0));
    L1i_read_i = 1'b0;
    L2_ready   = 1'b0;
    L2_rdata   = '0;
    tick();
    chk("t1_c3_i_ready", 128'(L1i_ready), 128'(0));
    chk("t1_c3_d_ready", 128'(L1d_ready), 128'(0));
    chk("t1_c3_busy",    128'(arb_busy_o), 128'(0));
    chk("t1_c3_i_rdata", 128'(L1i_rdata_o), 128'(PAT_A5));

    // simultaneous I read and D write after reset: I first, then D directly from DONE
    do_reset();
    L1i_read_i  = 1'b1;
    L1i_addr_i  = 28'h0000030;
    L1d_write_i = 1'b1;
    L1d_addr_i  = 28'h0000020;
    L1d_wdata_i = 128'h1234;
    tick();
    chk("t2_first_grant", 128'(arb_grant_d_o), 128'(0));
    chk("t2_i_addr",      128'(L2_addr), 128'(28'h0000030));
    chk("t2_i_write",     128'(L2_write), 128'(0));
    L2_ready = 1'b1;
    L2_rdata = PAT_55;
    tick();
    chk("t2_i_ready", 128'(L1i_ready), 128'(1));
    chk("t2_i_rdata", 128'(L1i_rdata_o), 128'(PAT_55));
    chk("t2_done_write", 128'(L2_write), 128'(0));
    L1i_read_i = 1'b0;
    L2_ready   = 1'b0;
    tick();
    chk("t2_d_grant", 128'(arb_grant_d_o), 128'(1));
    chk("t2_d_write", 128'(L2_write), 128'(1));
    chk("t2_d_read",  128'(L2_read), 128'(0));
    chk("t2_d_addr",  128'(L2_addr), 128'(28'h0000020));
    chk("t2_d_wdata", 128'(L2_wdata), 128'(128'h1234));
    L2_ready = 1'b1;
    L2_rdata = PAT_FF;
    tick();
    chk("t2_d_ready", 128'(L1d_ready), 128'(1));
    chk("t2_d_rdata", 128'(L1d_rdata_o), 128'(0));
    L1d_write_i = 1'b0;
    L2_ready    = 1'b0;
    tick();
    chk("t2_idle_busy", 128'(arb_busy_o), 128'(0));

    // both continuously reading, L2 latency 4: expect I,D,I,D,I,D (last grant was D)
    L1i_read_i = 1'b1;
    L1i_addr_i = 28'h0000100;
    L1d_read_i = 1'b1;
    L1d_addr_i = 28'h0000200;
    i_exp = L1i_rdata_o;
    d_exp = L1d_rdata_o;
    tick();
    for (int k = 0; k < 6; k++) begin
      own_d = (k % 2) == 1;
      chk($sformatf("t3_grant_%0d", k), 128'(arb_grant_d_o), 128'(own_d));
      chk($sformatf("t3_read_%0d", k),  128'(L2_read), 128'(1));
      chk($sformatf("t3_addr_%0d", k),  128'(L2_addr),
          128'(own_d ? 28'h0000200 : 28'h0000100));
      for (int c = 0; c < 4; c++) begin
        L2_ready = (c == 3);
        L2_rdata = 128'(k + 1) << 64 | 128'(k + 7);
        if (c < 3) begin
          tick();
          chk($sformatf("t3_wait_ready_%0d_%0d", k, c), 128'({L1i_ready, L1d_ready}), 128'(0));
        end
      end
      if (own_d) d_exp = 128'(k + 1) << 64 | 128'(k + 7);
      else       i_exp = 128'(k + 1) << 64 | 128'(k + 7);
      tick();
      L2_ready = 1'b0;
      chk($sformatf("t3_i_ready_%0d", k), 128'(L1i_ready), 128'(!own_d));
      chk($sformatf("t3_d_ready_%0d", k), 128'(L1d_ready), 128'(own_d));
      chk($sformatf("t3_done_strobes_%0d", k), 128'({L2_read, L2_write}), 128'(0));
      chk($sformatf("t3_done_addr_%0d", k), 128'(L2_addr), 128'(0));
      chk($sformatf("t3_i_rdata_%0d", k), 128'(L1i_rdata_o), 128'(i_exp));
      chk($sformatf("t3_d_rdata_%0d", k), 128'(L1d_rdata_o), 128'(d_exp));
      if (k == 5) begin
        L1i_read_i = 1'b0;
        L1d_read_i = 1'b0;
      end
      tick();
      chk($sformatf("t3_pulse_end_%0d", k), 128'({L1i_ready, L1d_ready}), 128'(0));
    end
    chk("t3_final_idle", 128'(arb_busy_o), 128'(0));

    // D read+write together: write wins, rdata untouched
    L1d_read_i  = 1'b1;
    L1d_write_i = 1'b1;
    L1d_addr_i  = 28'h0000040;
    L1d_wdata_i = 128'hBEEF;
    tick();
    chk("t4_write", 128'(L2_write), 128'(1));
    chk("t4_read",  128'(L2_read), 128'(0));
    L2_ready = 1'b1;
    L2_rdata = 128'hDEAD;
    tick();
    chk("t4_d_ready", 128'(L1d_ready), 128'(1));
    chk("t4_d_rdata", 128'(L1d_rdata_o), 128'(d_exp));
    L1d_read_i  = 1'b0;
    L1d_write_i = 1'b0;
    L2_ready    = 1'b0;
    tick();

    // D read aborted before L2_ready
    L1d_read_i = 1'b1;
    L1d_addr_i = 28'h0000050;
    tick();
    chk("t5_read", 128'(L2_read), 128'(1));
    L2_rdata = PAT_A5;
    tick();
    chk("t5_still_busy", 128'(arb_busy_o), 128'(1));
    L1d_read_i = 1'b0;
    tick();
    chk("t5_abort_busy",  128'(arb_busy_o), 128'(0));
    chk("t5_abort_ready", 128'(L1d_ready), 128'(0));
    chk("t5_abort_rdata", 128'(L1d_rdata_o), 128'(d_exp));
    tick();
    chk("t5_no_late_ready", 128'(L1d_ready), 128'(0));

    // reset in the 2nd SERVE_D cycle, then a tie goes to I
    L1d_read_i = 1'b1;
    L1d_addr_i = 28'h0000060;
    tick();
    chk("t6_serve_d", 128'(arb_grant_d_o), 128'(1));
    tick();
    proc_reset = 1'b1;
    tick();
    proc_reset = 1'b0;
    chk("t6_rst_strobes", 128'({L2_read, L2_write}), 128'(0));
    chk("t6_rst_busy",    128'(arb_busy_o), 128'(0));
    chk("t6_rst_i_rdata", 128'(L1i_rdata_o), 128'(0));
    chk("t6_rst_d_rdata", 128'(L1d_rdata_o), 128'(0));
    chk("t6_rst_grant",   128'(arb_grant_d_o), 128'(1));
    L1i_read_i = 1'b1;
    L1i_addr_i = 28'h0000070;
    tick();
    chk("t6_tie_grant", 128'(arb_grant_d_o), 128'(0));
    chk("t6_tie_addr",  128'(L2_addr), 128'(28'h0000070));
    chk("t6_tie_read",  128'(L2_read), 128'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
